oldland_dbg_reg_ctrl: RTL and testbench

Sequences debug-unit register reads and writes into the CPU register file's debug port. Accepts single-register or dump-all requests over a valid/ready handshake. Raises a halt request and waits for the core to halt before it owns the port. Drives the register file's dbg_en/sel/write lines, absorbs its one-cycle registered read latency, and returns results over a valid/ready response channel.

---
 rtl/oldland_dbg_reg_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_oldland_dbg_reg_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_dbg_reg_ctrl.sv
// Debug register controller: halts the core, then sequences single-register or
// dump-all accesses through the register file debug port with valid/ready responses.
module oldland_dbg_reg_ctrl #(
   parameter int unsigned HALT_TIMEOUT = 255,
   parameter int unsigned CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic        req_dump,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [3:0]  resp_idx,
   output logic        resp_last,
   output logic        resp_err,
   output logic        halt_req,
   input  logic        cpu_halted,
   output logic        dbg_en,
   output logic [3:0]  dbg_reg_sel,
   output logic [31:0] dbg_reg_wr_val,
   output logic        dbg_reg_wr_en,
   input  logic [31:0] dbg_reg_val
);

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(15);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(HALT_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_WAIT,
      ST_ACCESS,
      ST_READ_WAIT,
      ST_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic                dump_q, dump_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_pulse_q, wr_pulse_d;

   logic                resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_d;
   logic [IDX_W-1:0]    resp_idx_d;
   logic                resp_last_d;
   logic                resp_err_d;
   logic                halt_req_d;
   logic                dbg_en_d;
   logic [IDX_W-1:0]    dbg_reg_sel_d;
   logic [DATA_W-1:0]   dbg_reg_wr_val_d;

   logic                accept;
   logic                enter_access;
   logic                enter_err;

   assign req_ready = (state_q == ST_IDLE) & ~rst;
   assign accept    = req_valid & req_ready;

   // A write strobe never reaches the register file once the core has left halt.
   assign dbg_reg_wr_en = wr_pulse_q & cpu_halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         wr_q           <= 1'b0;
         dump_q         <= 1'b0;
         idx_q          <= '0;
         wdata_q        <= '0;
         wr_pulse_q     <= 1'b0;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         resp_idx       <= '0;
         resp_last      <= 1'b0;
         resp_err       <= 1'b0;
         halt_req       <= 1'b0;
         dbg_en         <= 1'b0;
         dbg_reg_sel    <= '0;
         dbg_reg_wr_val <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wr_q           <= wr_d;
         dump_q         <= dump_d;
         idx_q          <= idx_d;
         wdata_q        <= wdata_d;
         wr_pulse_q     <= wr_pulse_d;
         resp_valid     <= resp_valid_d;
         resp_rdata     <= resp_rdata_d;
         resp_idx       <= resp_idx_d;
         resp_last      <= resp_last_d;
         resp_err       <= resp_err_d;
         halt_req       <= halt_req_d;
         dbg_en         <= dbg_en_d;
         dbg_reg_sel    <= dbg_reg_sel_d;
         dbg_reg_wr_val <= dbg_reg_wr_val_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      wr_d             = wr_q;
      dump_d           = dump_q;
      idx_d            = idx_q;
      wdata_d          = wdata_q;
      wr_pulse_d       = 1'b0;
      resp_valid_d     = resp_valid;
      resp_rdata_d     = resp_rdata;
      resp_idx_d       = resp_idx;
      resp_last_d      = resp_last;
      resp_err_d       = resp_err;
      halt_req_d       = halt_req;
      dbg_en_d         = dbg_en;
      dbg_reg_sel_d    = dbg_reg_sel;
      dbg_reg_wr_val_d = dbg_reg_wr_val;
      enter_access     = 1'b0;
      enter_err        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               wr_d    = req_wr;
               dump_d  = req_dump;
               idx_d   = req_dump ? '0 : req_sel;
               wdata_d = req_wdata;
               if (cpu_halted) begin
                  enter_access = 1'b1;
               end else begin
                  halt_req_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = ST_HALT_WAIT;
               end
            end
         end

         ST_HALT_WAIT: begin
            if (cpu_halted) begin
               enter_access = 1'b1;
            end else if (cnt_q == TIMEOUT_CNT) begin
               enter_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_ACCESS: begin
            if (!cpu_halted) begin
               enter_err = 1'b1;
            end else begin
               state_d = ST_READ_WAIT;
            end
         end

         // Port A is registered: the value selected in ACCESS is visible here.
         ST_READ_WAIT: begin
            if (!cpu_halted) begin
               enter_err = 1'b1;
            end else begin
               state_d      = ST_RESP;
               dbg_en_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = dbg_reg_val;
               resp_idx_d   = idx_q;
               resp_err_d   = 1'b0;
               resp_last_d  = ~dump_q | (idx_q == LAST_IDX);
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (dump_q && (idx_q != LAST_IDX) && !resp_err) begin
                  idx_d        = idx_q + IDX_W'(1);
                  enter_access = 1'b1;
               end else begin
                  halt_req_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Common entry into ACCESS; a dump never strobes a write.
      if (enter_access) begin
         state_d          = ST_ACCESS;
         dbg_en_d         = 1'b1;
         dbg_reg_sel_d    = idx_d;
         dbg_reg_wr_val_d = wdata_d;
         wr_pulse_d       = wr_d & ~dump_d;
      end

      if (enter_err) begin
         state_d      = ST_RESP;
         dbg_en_d     = 1'b0;
         resp_valid_d = 1'b1;
         resp_rdata_d = '0;
         resp_idx_d   = idx_d;
         resp_last_d  = 1'b1;
         resp_err_d   = 1'b1;
      end
   end

endmodule

// File: tb/tb_oldland_dbg_reg_ctrl.sv
// Bench for oldland_dbg_reg_ctrl: register-file model on the debug port and a
// response reference model driven by directed and randomized requests.
module tb_oldland_dbg_reg_ctrl;

   localparam int unsigned TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic        req_dump;
   logic [3:0]  req_sel;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [3:0]  resp_idx;
   logic        resp_last;
   logic        resp_err;
   logic        halt_req;
   logic        cpu_halted;
   logic        dbg_en;
   logic [3:0]  dbg_reg_sel;
   logic [31:0] dbg_reg_wr_val;
   logic        dbg_reg_wr_en;
   logic [31:0] dbg_reg_val;

   always #5 clk = ~clk;

   oldland_dbg_reg_ctrl #(
      .HALT_TIMEOUT(TIMEOUT),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wr        (req_wr),
      .req_dump      (req_dump),
      .req_sel       (req_sel),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_idx      (resp_idx),
      .resp_last     (resp_last),
      .resp_err      (resp_err),
      .halt_req      (halt_req),
      .cpu_halted    (cpu_halted),
      .dbg_en        (dbg_en),
      .dbg_reg_sel   (dbg_reg_sel),
      .dbg_reg_wr_val(dbg_reg_wr_val),
      .dbg_reg_wr_en (dbg_reg_wr_en),
      .dbg_reg_val   (dbg_reg_val)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [3:0]  idx;
      logic        last;
      logic        err;
   } resp_t;

   resp_t       expq[$];
   logic [31:0] ref_rf [16];
   logic [31:0] rf [16];
   logic        ld_en;
   logic [3:0]  ld_idx;
   logic [31:0] ld_val;

   int          vec = 0;
   int          mis = 0;
   int          n_dben, n_wren, n_halt;
   logic [3:0]  wr_sel_seen;
   bit          halt_auto;
   int          halt_delay, hd_cnt;

   int          first, cyc, n_resp, kind;
   logic [3:0]  rs;
   logic [31:0] rw;
   bit          rwr, rdmp;

   // Register file: registered port A read, debug write port, bench preload port.
   always @(posedge clk) begin
      if (ld_en) rf[ld_idx] <= ld_val;
      else if (dbg_reg_wr_en) rf[dbg_reg_sel] <= dbg_reg_wr_val;
      dbg_reg_val <= rf[dbg_reg_sel];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (dbg_en === 1'b1) n_dben++;
      if (dbg_reg_wr_en === 1'b1) begin
         n_wren++;
         wr_sel_seen = dbg_reg_sel;
      end
      if (halt_req === 1'b1) n_halt++;
      // Core model: halts some cycles after being asked.
      if (halt_auto && halt_req === 1'b1 && cpu_halted == 1'b0) begin
         if (hd_cnt >= halt_delay) cpu_halted = 1'b1;
         else hd_cnt++;
      end
   endtask

   task automatic clr_stats();
      n_dben = 0;
      n_wren = 0;
      n_halt = 0;
      wr_sel_seen = 4'd0;
   endtask

   task automatic load(input logic [3:0] idx, input logic [31:0] val);
      ld_en  = 1'b1;
      ld_idx = idx;
      ld_val = val;
      ref_rf[idx] = val;
      tick();
      ld_en = 1'b0;
   endtask

   function automatic void exp_single(input bit wr, input logic [3:0] sel, input logic [31:0] wd);
      resp_t r;
      r.rdata = ref_rf[sel];
      r.idx   = sel;
      r.last  = 1'b1;
      r.err   = 1'b0;
      expq.push_back(r);
      if (wr) ref_rf[sel] = wd;
   endfunction

   function automatic void exp_dump();
      resp_t r;
      for (int i = 0; i < 16; i++) begin
         r.rdata = ref_rf[i];
         r.idx   = 4'(i);
         r.last  = (i == 15);
         r.err   = 1'b0;
         expq.push_back(r);
      end
   endfunction

   function automatic void exp_err(input logic [3:0] sel);
      resp_t r;
      r.rdata = 32'd0;
      r.idx   = sel;
      r.last  = 1'b1;
      r.err   = 1'b1;
      expq.push_back(r);
   endfunction

   task automatic send(input bit wr, input bit dump, input logic [3:0] sel, input logic [31:0] wd);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_dump  = dump;
      req_sel   = sel;
      req_wdata = wd;
      tick();
      req_valid = 1'b0;
      req_wr    = 1'($urandom_range(0, 1));
      req_dump  = 1'($urandom_range(0, 1));
      req_sel   = 4'($urandom_range(0, 15));
      req_wdata = $urandom();
      chk("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   // Drains the expected-response queue, optionally stalling resp_ready at random.
   task automatic collect(input bit rand_ready, input int budget, output int first_resp);
      int c;
      c = 0;
      first_resp = -1;
      while (expq.size() != 0 && c < budget) begin
         tick();
         c++;
         if (resp_valid === 1'b1) begin
            if (first_resp < 0) first_resp = c;
            chk("resp_rdata", resp_rdata, expq[0].rdata);
            chk("resp_idx", 32'(resp_idx), 32'(expq[0].idx));
            chk("resp_last", 32'(resp_last), 32'(expq[0].last));
            chk("resp_err", 32'(resp_err), 32'(expq[0].err));
            chk("dbg_en_in_resp", 32'(dbg_en), 32'd0);
            resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_ready) void'(expq.pop_front());
         end else begin
            resp_ready = 1'b0;
         end
      end
      chk("resp_pending", 32'(expq.size()), 32'd0);
      expq.delete();
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_idx"}, 32'(resp_idx), 32'd0);
      chk({tag, "_resp_last"}, 32'(resp_last), 32'd0);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_halt_req"}, 32'(halt_req), 32'd0);
      chk({tag, "_dbg_en"}, 32'(dbg_en), 32'd0);
      chk({tag, "_dbg_reg_sel"}, 32'(dbg_reg_sel), 32'd0);
      chk({tag, "_dbg_reg_wr_val"}, dbg_reg_wr_val, 32'd0);
      chk({tag, "_dbg_reg_wr_en"}, 32'(dbg_reg_wr_en), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_dump   = 1'b0;
      req_sel    = 4'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;
      cpu_halted = 1'b0;
      ld_en      = 1'b0;
      ld_idx     = 4'd0;
      ld_val     = 32'd0;
      halt_auto  = 1'b0;
      halt_delay = 0;
      hd_cnt     = 0;
      clr_stats();

      // Reset values
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      #1;
      chk("req_ready_after_reset", 32'(req_ready), 32'd1);

      for (int i = 0; i < 16; i++) load(4'(i), $urandom());
      load(4'd5, 32'h1234_5678);

      // Single read with the core already halted
      cpu_halted = 1'b1;
      clr_stats();
      exp_single(1'b0, 4'd5, 32'd0);
      send(1'b0, 1'b0, 4'd5, 32'd0);
      collect(1'b0, 50, first);
      chk("read_latency", 32'(first), 32'd2);
      chk("read_dbg_en_cycles", 32'(n_dben), 32'd2);
      chk("read_halt_req_cycles", 32'(n_halt), 32'd0);
      chk("read_wr_en_cycles", 32'(n_wren), 32'd0);

      // Write that must first halt the core
      cpu_halted = 1'b0;
      halt_auto  = 1'b1;
      halt_delay = 4;
      hd_cnt     = 0;
      clr_stats();
      exp_single(1'b1, 4'd3, 32'hDEAD_BEEF);
      send(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF);
      collect(1'b0, 60, first);
      chk("write_halt_req_seen", 32'(n_halt > 0), 32'd1);
      chk("write_wr_en_cycles", 32'(n_wren), 32'd1);
      chk("write_wr_sel", 32'(wr_sel_seen), 32'd3);
      chk("write_halt_req_dropped", 32'(halt_req), 32'd0);
      halt_auto = 1'b0;
      exp_single(1'b0, 4'd3, 32'd0);
      send(1'b0, 1'b0, 4'd3, 32'd0);
      collect(1'b0, 50, first);

      // Halt timeout
      cpu_halted = 1'b0;
      clr_stats();
      exp_err(4'd11);
      send(1'b0, 1'b0, 4'd11, 32'd0);
      collect(1'b0, 60, first);
      chk("timeout_latency", 32'(first), 32'(TIMEOUT + 1));
      chk("timeout_dbg_en_cycles", 32'(n_dben), 32'd0);
      chk("timeout_halt_req_seen", 32'(n_halt > 0), 32'd1);
      chk("timeout_halt_req_dropped", 32'(halt_req), 32'd0);

      // Dump with rN = N*0x11 and random backpressure; req_wr must be ignored
      for (int i = 0; i < 16; i++) load(4'(i), 32'(i) * 32'h11);
      cpu_halted = 1'b1;
      clr_stats();
      exp_dump();
      send(1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF);
      collect(1'b1, 400, first);
      chk("dump_wr_en_cycles", 32'(n_wren), 32'd0);
      chk("dump_dbg_en_cycles", 32'(n_dben), 32'd32);

      // Halt lost during READ_WAIT of a write: write already landed
      cpu_halted = 1'b1;
      send(1'b1, 1'b0, 4'd7, 32'hCAFE_F00D);
      chk("rw_drop_access_dbg_en", 32'(dbg_en), 32'd1);
      chk("rw_drop_access_wr_en", 32'(dbg_reg_wr_en), 32'd1);
      chk("rw_drop_access_sel", 32'(dbg_reg_sel), 32'd7);
      tick();
      chk("rw_drop_readwait_dbg_en", 32'(dbg_en), 32'd1);
      cpu_halted = 1'b0;
      #1;
      chk("rw_drop_wr_en_gated", 32'(dbg_reg_wr_en), 32'd0);
      ref_rf[7] = 32'hCAFE_F00D;
      exp_err(4'd7);
      collect(1'b0, 20, first);
      chk("rw_drop_latency", 32'(first), 32'd1);
      cpu_halted = 1'b1;
      exp_single(1'b0, 4'd7, 32'd0);
      send(1'b0, 1'b0, 4'd7, 32'd0);
      collect(1'b0, 50, first);

      // Halt lost during ACCESS of a write: strobe suppressed, register untouched
      send(1'b1, 1'b0, 4'd9, 32'h5A5A_A5A5);
      chk("acc_drop_wr_en_before", 32'(dbg_reg_wr_en), 32'd1);
      cpu_halted = 1'b0;
      #1;
      chk("acc_drop_wr_en_gated", 32'(dbg_reg_wr_en), 32'd0);
      exp_err(4'd9);
      collect(1'b0, 20, first);
      chk("acc_drop_latency", 32'(first), 32'd1);
      cpu_halted = 1'b1;
      exp_single(1'b0, 4'd9, 32'd0);
      send(1'b0, 1'b0, 4'd9, 32'd0);
      collect(1'b0, 50, first);

      // Reset in the middle of a dump
      cpu_halted = 1'b1;
      send(1'b0, 1'b1, 4'd0, 32'd0);
      resp_ready = 1'b1;
      n_resp = 0;
      cyc = 0;
      while (!(dbg_en === 1'b1 && dbg_reg_sel == 4'd7) && cyc < 100) begin
         tick();
         cyc++;
         if (resp_valid === 1'b1) n_resp++;
      end
      chk("mid_dump_resp_before_rst", 32'(n_resp), 32'd7);
      rst = 1'b1;
      resp_ready = 1'b0;
      tick();
      chk_zero("mid_dump_rst");
      rst = 1'b0;
      #1;
      chk("req_ready_after_mid_rst", 32'(req_ready), 32'd1);
      exp_single(1'b0, 4'd12, 32'd0);
      send(1'b0, 1'b0, 4'd12, 32'd0);
      collect(1'b0, 50, first);
      chk("post_rst_read_latency", 32'(first), 32'd2);

      // Randomized traffic
      for (int t = 0; t < 30; t++) begin
         kind = int'($urandom_range(0, 9));
         rs   = 4'($urandom_range(0, 15));
         rw   = $urandom();
         rdmp = (kind == 0);
         rwr  = (kind >= 5);
         if ($urandom_range(0, 1) == 1) begin
            cpu_halted = 1'b0;
            halt_auto  = 1'b1;
            halt_delay = int'($urandom_range(0, 5));
            hd_cnt     = 0;
         end else begin
            cpu_halted = 1'b1;
            halt_auto  = 1'b0;
         end
         clr_stats();
         if (rdmp) exp_dump();
         else exp_single(rwr, rs, rw);
         send(rwr, rdmp, rs, rw);
         collect(1'b1, 600, first);
         chk("rand_wr_en_cycles", 32'(n_wren), (rwr && !rdmp) ? 32'd1 : 32'd0);
         chk("rand_halt_req_dropped", 32'(halt_req), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
